// File: rtl/signal_period_meter_if.sv
// rtl/signal_period_meter_if.sv - sample stream in, period measurement results out
interface signal_period_meter_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 24
);
    logic [DATA_W-1:0] sample_i;
    logic              sample_valid_i;
    logic [CNT_W-1:0]  period_o;
    logic [CNT_W-1:0]  nsamp_o;
    logic [DATA_W-1:0] min_o;
    logic [DATA_W-1:0] max_o;
    logic              result_valid_o;
    logic              locked_o;
    logic              timeout_o;

    modport master (
        output sample_i, sample_valid_i,
        input  period_o, nsamp_o, min_o, max_o, result_valid_o, locked_o, timeout_o
    );

    modport slave (
        input  sample_i, sample_valid_i,
        output period_o, nsamp_o, min_o, max_o, result_valid_o, locked_o, timeout_o
    );
endinterface

// File: rtl/signal_period_meter.sv
// rtl/signal_period_meter.sv - rising midscale-crossing period/min/max meter with hysteresis
module signal_period_meter #(
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 24,
    parameter int HYST    = 256,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    signal_period_meter_if.slave  bus
);
    typedef enum logic [1:0] {ARM, FIRST, MEAS_HI, MEAS_LO} state_e;

    localparam longint MID_L   = longint'(1) << (DATA_W - 1);
    localparam longint FULL_L  = (longint'(1) << DATA_W) - 1;
    localparam longint HYST_L  = longint'(HYST);
    localparam longint TH_LO_L = (MID_L > HYST_L) ? MID_L - HYST_L : 64'sd0;
    localparam longint TH_HI_L = (MID_L + HYST_L > FULL_L) ? FULL_L : MID_L + HYST_L;
    localparam logic [DATA_W-1:0] TH_LO = DATA_W'(TH_LO_L);
    localparam logic [DATA_W-1:0] TH_HI = DATA_W'(TH_HI_L);

    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, ns_q, ns_d;
    logic [DATA_W-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [CNT_W-1:0]  period_q, period_d, nsamp_q, nsamp_d;
    logic [DATA_W-1:0] min_q, min_d, max_q, max_d;
    logic              result_valid_q, result_valid_d;
    logic              locked_q, locked_d, timeout_q, timeout_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

    logic smp_lo, smp_hi, trig, result, to_hit, meas;

    assign smp_lo = bus.sample_valid_i && (bus.sample_i < TH_LO);
    assign smp_hi = bus.sample_valid_i && (bus.sample_i >= TH_HI);
    assign meas   = (state_q == MEAS_HI) || (state_q == MEAS_LO);
    assign to_hit = (state_q != ARM) && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARM;
        end else begin
            state_q <= state_d;
        end
    end

    // A trigger always beats a timeout landing on the same cycle.
    always_comb begin
        state_d = state_q;
        trig    = 1'b0;
        case (state_q)
            ARM:     if (smp_lo) state_d = FIRST;
            FIRST:   if (smp_hi) begin trig = 1'b1; state_d = MEAS_HI; end
            MEAS_HI: if (smp_lo) state_d = MEAS_LO;
            MEAS_LO: if (smp_hi) begin trig = 1'b1; state_d = MEAS_HI; end
            default: state_d = ARM;
        endcase
        if (to_hit && !trig) state_d = ARM;
    end

    assign result = trig && (state_q == MEAS_LO);

    always_comb begin
        cnt_d          = cnt_q;
        ns_d           = ns_q;
        lo_d           = lo_q;
        hi_d           = hi_q;
        period_d       = period_q;
        nsamp_d        = nsamp_q;
        min_d          = min_q;
        max_d          = max_q;
        result_valid_d = 1'b0;
        locked_d       = locked_q;
        timeout_d      = timeout_q;
        to_cnt_d       = (state_q == ARM || trig || to_hit) ? '0 : to_cnt_q + TO_W'(1);

        // The trigger sample opens the new period; the closing one is not counted in the old.
        if (trig) begin
            cnt_d = CNT_W'(1);
            ns_d  = CNT_W'(1);
            lo_d  = bus.sample_i;
            hi_d  = bus.sample_i;
        end else if (meas) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            if (bus.sample_valid_i) begin
                ns_d = (ns_q == CNT_MAX) ? ns_q : ns_q + CNT_W'(1);
                if (bus.sample_i < lo_q) lo_d = bus.sample_i;
                if (bus.sample_i > hi_q) hi_d = bus.sample_i;
            end
        end

        if (result) begin
            period_d       = cnt_q;
            nsamp_d        = ns_q;
            min_d          = lo_q;
            max_d          = hi_q;
            result_valid_d = 1'b1;
            locked_d       = 1'b1;
            timeout_d      = 1'b0;
        end else if (to_hit) begin
            locked_d  = 1'b0;
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            ns_q           <= '0;
            lo_q           <= '0;
            hi_q           <= '0;
            period_q       <= '0;
            nsamp_q        <= '0;
            min_q          <= '0;
            max_q          <= '0;
            result_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
            to_cnt_q       <= '0;
        end else begin
            cnt_q          <= cnt_d;
            ns_q           <= ns_d;
            lo_q           <= lo_d;
            hi_q           <= hi_d;
            period_q       <= period_d;
            nsamp_q        <= nsamp_d;
            min_q          <= min_d;
            max_q          <= max_d;
            result_valid_q <= result_valid_d;
            locked_q       <= locked_d;
            timeout_q      <= timeout_d;
            to_cnt_q       <= to_cnt_d;
        end
    end

    assign bus.period_o       = period_q;
    assign bus.nsamp_o        = nsamp_q;
    assign bus.min_o          = min_q;
    assign bus.max_o          = max_q;
    assign bus.result_valid_o = result_valid_q;
    assign bus.locked_o       = locked_q;
    assign bus.timeout_o      = timeout_q;
endmodule

// File: tb/tb_signal_period_meter.sv
// tb/tb_signal_period_meter.sv - scoreboard bench for signal_period_meter
module tb_signal_period_meter;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 24;
    localparam logic [DATA_W-1:0] TH_HI = 16'h8100;

    typedef struct {
        logic [CNT_W-1:0]  period;
        logic [CNT_W-1:0]  nsamp;
        logic [DATA_W-1:0] mn;
        logic [DATA_W-1:0] mx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    signal_period_meter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus_m ();
    signal_period_meter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus_s ();

    signal_period_meter #(.DATA_W(DATA_W), .CNT_W(CNT_W), .HYST(256), .TIMEOUT(1000)) dut (
        .clk(clk), .rst(rst), .bus(bus_m)
    );
    signal_period_meter #(.DATA_W(DATA_W), .CNT_W(CNT_W), .HYST(256), .TIMEOUT(8192)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   res_m    = 0;
    int   res_s    = 0;
    exp_t exp_m[$];
    exp_t exp_s[$];
    exp_t em, es;

    logic [DATA_W-1:0] sine [1024];
    logic [DATA_W-1:0] s_min, s_max;
    int   k_trig;
    int   sp;
    real  r;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    task automatic check_state(input string tag, input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] ns,
                               input logic [DATA_W-1:0] mn, input logic [DATA_W-1:0] mx,
                               input logic lk, input logic to);
        check_eq({tag, "_period"},  64'(bus_m.period_o),  64'(p));
        check_eq({tag, "_nsamp"},   64'(bus_m.nsamp_o),   64'(ns));
        check_eq({tag, "_min"},     64'(bus_m.min_o),     64'(mn));
        check_eq({tag, "_max"},     64'(bus_m.max_o),     64'(mx));
        check_eq({tag, "_locked"},  64'(bus_m.locked_o),  64'(lk));
        check_eq({tag, "_timeout"}, 64'(bus_m.timeout_o), 64'(to));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input logic [DATA_W-1:0] s, input logic v);
        bus_m.sample_i       = s;
        bus_m.sample_valid_i = v;
        tick();
    endtask

    task automatic drive_s(input logic [DATA_W-1:0] s, input logic v);
        bus_s.sample_i       = s;
        bus_s.sample_valid_i = v;
        tick();
    endtask

    // Square wave, valid every cycle; a result is expected at each period's first high sample from first_res on.
    task automatic run_square(input int nlo, input int nhi, input logic [DATA_W-1:0] lo,
                              input logic [DATA_W-1:0] hi, input int nper, input int first_res);
        for (int p = 0; p < nper; p++) begin
            for (int i = 0; i < nlo; i++) drive_m(lo, 1'b1);
            for (int i = 0; i < nhi; i++) begin
                if (i == 0 && p >= first_res)
                    exp_m.push_back(exp_t'{CNT_W'(nlo + nhi), CNT_W'(nlo + nhi), lo, hi});
                drive_m(hi, 1'b1);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus_m.result_valid_o === 1'b1) begin
            res_m++;
            check_eq("m_result_expected", 64'(exp_m.size() > 0), 64'd1);
            if (exp_m.size() > 0) begin
                em = exp_m.pop_front();
                check_eq("m_period", 64'(bus_m.period_o), 64'(em.period));
                check_eq("m_nsamp",  64'(bus_m.nsamp_o),  64'(em.nsamp));
                check_eq("m_min",    64'(bus_m.min_o),    64'(em.mn));
                check_eq("m_max",    64'(bus_m.max_o),    64'(em.mx));
            end
        end
        if (bus_s.result_valid_o === 1'b1) begin
            res_s++;
            check_eq("s_result_expected", 64'(exp_s.size() > 0), 64'd1);
            if (exp_s.size() > 0) begin
                es = exp_s.pop_front();
                check_eq("s_period", 64'(bus_s.period_o), 64'(es.period));
                check_eq("s_nsamp",  64'(bus_s.nsamp_o),  64'(es.nsamp));
                check_eq("s_min",    64'(bus_s.min_o),    64'(es.mn));
                check_eq("s_max",    64'(bus_s.max_o),    64'(es.mx));
            end
        end
    end

    initial begin
        bus_m.sample_i = '0;
        bus_m.sample_valid_i = 1'b0;
        bus_s.sample_i = '0;
        bus_s.sample_valid_i = 1'b0;

        rst = 1'b1;
        repeat (5) drive_m(DATA_W'($urandom), 1'($urandom));
        check_state("reset", '0, '0, '0, '0, 1'b0, 1'b0);
        check_eq("reset_rv", 64'(bus_m.result_valid_o), 64'd0);
        rst = 1'b0;
        bus_m.sample_valid_i = 1'b0;

        s_min = '1;
        s_max = '0;
        k_trig = -1;
        for (int i = 0; i < 1024; i++) begin
            r = 32767.5 + 32767.0 * $sin(2.0 * 3.141592653589793 * real'(i) / 1024.0);
            sine[i] = DATA_W'($rtoi(r));
            if (sine[i] < s_min) s_min = sine[i];
            if (sine[i] > s_max) s_max = sine[i];
            if (k_trig < 0 && sine[i] >= TH_HI) k_trig = i;
        end

        // Strobe spacing 4, switching to 2 exactly at a trigger so the following period is uniform.
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 1024; i++) begin
                if (p == 4 && i > k_trig) break;
                sp = (p < 3 || (p == 3 && i < k_trig)) ? 4 : 2;
                if (i == k_trig && p >= 2)
                    exp_s.push_back(exp_t'{(p == 4) ? CNT_W'(2048) : CNT_W'(4096), CNT_W'(1024), s_min, s_max});
                drive_s(sine[i], 1'b1);
                repeat (sp - 1) drive_s(sine[i], 1'b0);
            end
        end
        drive_s(16'h8000, 1'b0);
        check_eq("s_locked", 64'(bus_s.locked_o), 64'd1);
        check_eq("s_results", 64'(res_s), 64'd3);

        run_square(8, 8, 16'h1000, 16'hF000, 1, 1);
        check_eq("sq_unlocked_first", 64'(bus_m.locked_o), 64'd0);
        run_square(8, 8, 16'h1000, 16'hF000, 4, 0);
        check_eq("sq_locked", 64'(bus_m.locked_o), 64'd1);
        check_eq("sq_results", 64'(res_m), 64'd4);

        // Last trigger was 8 cycles ago; 992 more in-band samples reach 999.
        for (int i = 0; i < 250; i++) begin drive_m(16'h80C8, 1'b1); drive_m(16'h7F38, 1'b1); end
        for (int i = 0; i < 100; i++) begin drive_m(16'h80FF, 1'b1); drive_m(16'h7F00, 1'b1); end
        repeat (292) drive_m(16'h8000, 1'b1);
        check_state("pre_timeout", CNT_W'(16), CNT_W'(16), 16'h1000, 16'hF000, 1'b1, 1'b0);
        drive_m(16'h8000, 1'b1);
        check_state("timeout", CNT_W'(16), CNT_W'(16), 16'h1000, 16'hF000, 1'b0, 1'b1);

        run_square(8, 8, 16'h1000, 16'hF000, 1, 1);
        check_eq("timeout_sticky", 64'(bus_m.timeout_o), 64'd1);
        run_square(8, 8, 16'h1000, 16'hF000, 2, 0);
        check_eq("timeout_cleared", 64'(bus_m.timeout_o), 64'd0);
        check_eq("relocked", 64'(bus_m.locked_o), 64'd1);

        repeat (4) drive_m(16'h1000, 1'b1);
        rst = 1'b1;
        drive_m(16'h1000, 1'b1);
        rst = 1'b0;
        check_state("mid_reset", '0, '0, '0, '0, 1'b0, 1'b0);
        repeat (4) drive_m(16'h0000, 1'b1);
        run_square(5, 7, 16'h0000, 16'hFFFF, 3, 1);
        check_eq("mid_reset_locked", 64'(bus_m.locked_o), 64'd1);

        rst = 1'b1;
        drive_m(16'h8000, 1'b0);
        rst = 1'b0;
        run_square(1, 1, 16'h7EFF, 16'h8100, 4, 1);
        repeat (2) drive_m(16'h8000, 1'b0);

        check_eq("m_pending", 64'(exp_m.size()), 64'd0);
        check_eq("s_pending", 64'(exp_s.size()), 64'd0);
        check_eq("m_results_total", 64'(res_m), 64'd11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
